// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the bubble instruction and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter with load enable and next-PC select (PC+4 or branch target).
// The +4 adder wraps modulo 2^32 and also feeds the PC_PLUS_4 output path.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_load_en,
  input  logic        i_sel_branch,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus_4;
  logic [31:0] w_pc_next;

  assign w_pc_plus_4 = r_pc + 32'd4;
  assign w_pc_next   = i_sel_branch ? i_branch_target : w_pc_plus_4;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc <= RESET_PC;
    end else if (i_load_en) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_plus_4 = w_pc_plus_4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, runs the busy-wait handshake with instruction memory
// and writes IF/ID, inserting NOP bubbles for wait states and redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         STALL,
  input  logic         BRANCH_TAKEN,
  input  logic [31:0]  BRANCH_TARGET,
  output logic [31:0]  IMEM_ADDRESS,
  output logic         IMEM_READ,
  input  logic [31:0]  IMEM_READDATA,
  input  logic         IMEM_BUSYWAIT,
  output logic [31:0]  INSTRUCTION,
  output logic [31:0]  PC_PLUS_4,
  output logic         IF_ID_ENABLE,
  output fetch_state_e o_dbg_state
);

  // Memory handshake: a word is transferred in any cycle where IMEM_READ=1 and
  // IMEM_BUSYWAIT=0; while busy, IMEM_ADDRESS is held stable until that cycle.

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_drain_addr;
  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus_4;
  logic         w_pc_load;
  logic         w_pc_branch;
  logic         w_hold_load;
  logic         w_drain_load;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .CLK             (CLK),
    .RESET           (RESET),
    .i_load_en       (w_pc_load),
    .i_sel_branch    (w_pc_branch),
    .i_branch_target (BRANCH_TARGET),
    .o_pc            (w_pc),
    .o_pc_plus_4     (w_pc_plus_4)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= ST_IDLE;
      r_hold_instr <= '0;
      r_drain_addr <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (w_hold_load)  r_hold_instr <= IMEM_READDATA;
      if (w_drain_load) r_drain_addr <= w_pc;
    end
  end

  always_comb begin
    w_state_next = r_state;
    IMEM_READ    = 1'b0;
    IMEM_ADDRESS = w_pc;
    INSTRUCTION  = NOP_INSTR;
    PC_PLUS_4    = w_pc_plus_4;
    IF_ID_ENABLE = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_branch  = 1'b0;
    w_hold_load  = 1'b0;
    w_drain_load = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end

      ST_FETCH: begin
        IMEM_READ = 1'b1;
        if (BRANCH_TAKEN) begin
          IF_ID_ENABLE = 1'b1;
          w_pc_load    = 1'b1;
          w_pc_branch  = 1'b1;
          // An in-flight read must complete at its own address before redirecting.
          if (IMEM_BUSYWAIT) begin
            w_drain_load = 1'b1;
            w_state_next = ST_DRAIN;
          end
        end else if (!IMEM_BUSYWAIT && !STALL) begin
          INSTRUCTION  = IMEM_READDATA;
          IF_ID_ENABLE = 1'b1;
          w_pc_load    = 1'b1;
        end else if (!IMEM_BUSYWAIT) begin
          w_hold_load  = 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          IF_ID_ENABLE = ~STALL;
        end
      end

      ST_HOLD: begin
        if (BRANCH_TAKEN) begin
          IF_ID_ENABLE = 1'b1;
          w_pc_load    = 1'b1;
          w_pc_branch  = 1'b1;
          w_state_next = ST_FETCH;
        end else if (!STALL) begin
          INSTRUCTION  = r_hold_instr;
          IF_ID_ENABLE = 1'b1;
          w_pc_load    = 1'b1;
          w_state_next = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        IMEM_READ    = 1'b1;
        IMEM_ADDRESS = r_drain_addr;
        if (BRANCH_TAKEN) begin
          IF_ID_ENABLE = 1'b1;
          w_pc_load    = 1'b1;
          w_pc_branch  = 1'b1;
        end
        if (!IMEM_BUSYWAIT) begin
          w_state_next = ST_FETCH;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a memory model answers fetches,
// expected IF/ID captures are queued by the stimulus and checked on capture.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic         CLK;
  logic         RESET;
  logic         STALL;
  logic         BRANCH_TAKEN;
  logic [31:0]  BRANCH_TARGET;
  logic [31:0]  IMEM_ADDRESS;
  logic         IMEM_READ;
  logic [31:0]  IMEM_READDATA;
  logic         IMEM_BUSYWAIT;
  logic [31:0]  INSTRUCTION;
  logic [31:0]  PC_PLUS_4;
  logic         IF_ID_ENABLE;
  fetch_state_e o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic mon_on = 1'b0;
  logic [63:0] exp_q[$];

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .IMEM_READ     (IMEM_READ),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .INSTRUCTION   (INSTRUCTION),
    .PC_PLUS_4     (PC_PLUS_4),
    .IF_ID_ENABLE  (IF_ID_ENABLE),
    .o_dbg_state   (o_dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  always_comb IMEM_READDATA = mem_word(IMEM_ADDRESS);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver helpers: expect one IF/ID capture, then run one cycle
  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  task automatic cyc(input string tag, input logic exp_read, input logic [31:0] exp_addr);
    @(negedge CLK);
    check({tag, "_read"}, {63'd0, IMEM_READ}, {63'd0, exp_read});
    check({tag, "_addr"}, {32'd0, IMEM_ADDRESS}, {32'd0, exp_addr});
    @(posedge CLK);
    #1;
  endtask

  // scoreboard: every IF/ID capture must match the head of the expected queue
  always @(negedge CLK) begin
    if (mon_on && IF_ID_ENABLE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_capture", {INSTRUCTION, PC_PLUS_4}, 64'hxxxx_xxxx_xxxx_xxxx);
      end else begin
        check("capture", {INSTRUCTION, PC_PLUS_4}, exp_q.pop_front());
      end
    end else if (mon_on && IF_ID_ENABLE !== 1'b0) begin
      check("enable_known", {63'd0, IF_ID_ENABLE}, 64'd0);
    end
  end

  initial begin
    RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = 32'h0; IMEM_BUSYWAIT = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    mon_on = 1'b1;

    // reset state
    @(negedge CLK);
    check("rst_read",  {63'd0, IMEM_READ}, 64'd0);
    check("rst_en",    {63'd0, IF_ID_ENABLE}, 64'd0);
    check("rst_out",   {INSTRUCTION, PC_PLUS_4}, {NOP_INSTR, 32'h4});
    check("rst_addr",  {32'd0, IMEM_ADDRESS}, 64'd0);
    check("rst_state", {62'd0, o_dbg_state}, {62'd0, ST_IDLE});
    @(posedge CLK); #1;

    // release reset: one idle cycle, then zero-wait fetches
    RESET = 1'b1;
    cyc("idle", 1'b0, 32'h0);
    push(32'h00A0_0093, 32'h4); cyc("f0", 1'b1, 32'h0);
    push(32'h0010_0113, 32'h8); cyc("f4", 1'b1, 32'h4);

    // three wait states at 0x8
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(NOP_INSTR, 32'hC); cyc("wait8", 1'b1, 32'h8);
    end
    IMEM_BUSYWAIT = 1'b0;
    push(mem_word(32'h8), 32'hC);  cyc("f8", 1'b1, 32'h8);
    push(mem_word(32'hC), 32'h10); cyc("fC", 1'b1, 32'hC);

    // stall on accept at 0x10: park in HOLD, release next
    STALL = 1'b1;
    cyc("stall_acc", 1'b1, 32'h10);
    check("hold_state", {62'd0, o_dbg_state}, {62'd0, ST_HOLD});
    cyc("stall_hold", 1'b0, 32'h10);
    STALL = 1'b0;
    push(mem_word(32'h10), 32'h14); cyc("hold_rel", 1'b0, 32'h10);
    push(mem_word(32'h14), 32'h18); cyc("f14", 1'b1, 32'h14);

    // branch with stall in the same fetch cycle
    STALL = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
    push(NOP_INSTR, 32'h1C); cyc("br_stall", 1'b1, 32'h18);
    STALL = 1'b0; BRANCH_TAKEN = 1'b0;
    push(mem_word(32'h100), 32'h104); cyc("f100", 1'b1, 32'h100);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h20;
    push(NOP_INSTR, 32'h108); cyc("br20", 1'b1, 32'h104);

    // redirect during a busy read at 0x20, second redirect while draining
    BRANCH_TARGET = 32'h30; IMEM_BUSYWAIT = 1'b1;
    push(NOP_INSTR, 32'h24); cyc("br_busy", 1'b1, 32'h20);
    check("drain_state", {62'd0, o_dbg_state}, {62'd0, ST_DRAIN});
    BRANCH_TARGET = 32'h40;
    push(NOP_INSTR, 32'h34); cyc("drain_br", 1'b1, 32'h20);
    BRANCH_TAKEN = 1'b0;
    cyc("drain1", 1'b1, 32'h20);
    IMEM_BUSYWAIT = 1'b0;
    cyc("drain_done", 1'b1, 32'h20);
    push(mem_word(32'h40), 32'h44); cyc("f40", 1'b1, 32'h40);

    // PC wrap at the top of the address space
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    push(NOP_INSTR, 32'h48); cyc("br_top", 1'b1, 32'h44);
    BRANCH_TAKEN = 1'b0;
    push(mem_word(32'hFFFF_FFFC), 32'h0); cyc("f_top", 1'b1, 32'hFFFF_FFFC);
    push(32'h00A0_0093, 32'h4); cyc("f_wrap", 1'b1, 32'h0);

    // reset while draining abandons the read
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h80; IMEM_BUSYWAIT = 1'b1;
    push(NOP_INSTR, 32'h8); cyc("br_busy2", 1'b1, 32'h4);
    BRANCH_TAKEN = 1'b0;
    cyc("drain2", 1'b1, 32'h4);
    RESET = 1'b0;
    cyc("drain_rst", 1'b1, 32'h4);
    RESET = 1'b1; IMEM_BUSYWAIT = 1'b0;
    cyc("post_rst", 1'b0, 32'h0);
    push(32'h00A0_0093, 32'h4); cyc("f0_again", 1'b1, 32'h0);

    check("queue_empty", {32'd0, exp_q.size()}, 64'd0);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the RV32IM 5-stage pipeline. It is the writer side of the IF/ID pipeline register: it owns the PC and runs the busy-wait handshake with instruction memory. Each cycle it presents INSTRUCTION, PC_PLUS_4 and a capture enable to IF/ID. It absorbs memory wait states, hazard-unit stalls and EX-stage branch redirects, inserting NOP bubbles where no valid instruction exists.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- STALL  in  1  hazard unit: hold PC and IF/ID contents
- BRANCH_TAKEN  in  1  EX-stage redirect request
- BRANCH_TARGET  in  32  redirect address, valid with BRANCH_TAKEN
- IMEM_ADDRESS  out  32  fetch address
- IMEM_READ  out  1  read request
- IMEM_READDATA  in  32  instruction word
- IMEM_BUSYWAIT  in  1  memory busy; data valid when READ=1 and BUSYWAIT=0
- INSTRUCTION  out  32  to IF/ID INSTRUCTION
- PC_PLUS_4  out  32  to IF/ID PC_PLUS_4
- IF_ID_ENABLE  out  1  to IF/ID ENABLE

## Operation
- **State:** 32-bit PC; 32-bit hold buffer (HOLD_INSTR); 2-bit FSM with states IDLE, FETCH, HOLD, DRAIN.
- **Outputs:** combinational from state and inputs. In every case not listed below: INSTRUCTION=NOP_INSTR, PC_PLUS_4=PC+4, IF_ID_ENABLE=0.
- **IDLE:**
  - Entered on reset.
  - IMEM_READ=0.
  - Always goes to FETCH next cycle.
- **FETCH:**
  - IMEM_READ=1, IMEM_ADDRESS=PC.
  - **Accept** means BUSYWAIT=0 in this cycle.
  - **Priority 1, BRANCH_TAKEN=1:**
    - IF_ID_ENABLE=1, INSTRUCTION=NOP_INSTR.
    - PC<=BRANCH_TARGET.
    - If accept: stay in FETCH and discard the word. If not accept: go to DRAIN.
  - **Priority 2, accept and STALL=0:**
    - INSTRUCTION=IMEM_READDATA, PC_PLUS_4=PC+4, IF_ID_ENABLE=1.
    - PC<=PC+4.
  - **Priority 3, accept and STALL=1:**
    - HOLD_INSTR<=IMEM_READDATA.
    - Go to HOLD; PC unchanged.
  - **Priority 4, no accept:**
    - IF_ID_ENABLE=~STALL with INSTRUCTION=NOP_INSTR, which inserts a bubble when not stalled.
- **HOLD:**
  - IMEM_READ=0.
  - BRANCH_TAKEN: ENABLE=1 with NOP; PC<=target; buffer dropped; go to FETCH.
  - Else if STALL=0: INSTRUCTION=HOLD_INSTR, PC_PLUS_4=PC+4, ENABLE=1; PC<=PC+4; go to FETCH.
  - Else: remain in HOLD.
- **DRAIN:**
  - IMEM_READ=1, IMEM_ADDRESS=the pre-redirect address, kept stable; that address is held in a separate register captured on entry to DRAIN.
  - When BUSYWAIT=0: discard the data and go to FETCH at PC (the target).
  - BRANCH_TAKEN while in DRAIN: PC<=new target, ENABLE=1 with NOP, remain in DRAIN.
- **Arithmetic:** PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. PC[1:0] is never checked; misaligned targets are the decoder's concern.
- **Reset:** RESET=0 at a clock edge sets PC<=RESET_PC and state<=IDLE and clears HOLD_INSTR. Reset mid-transaction abandons any outstanding read; IMEM_READ drops the cycle after the edge.

## Timing
- Reset values, held while in IDLE after reset:
  - IMEM_READ=0, IF_ID_ENABLE=0.
  - INSTRUCTION=NOP_INSTR, PC_PLUS_4=RESET_PC+4.
  - IMEM_ADDRESS=RESET_PC.
- First IMEM_READ=1 occurs in the cycle after the first edge with RESET=1.
- Zero-wait memory: one instruction per cycle; combinational fetch-to-IF/ID latency 0, so the word is captured at the end of its fetch cycle.
- Wait state N (BUSYWAIT high for N cycles) produces N bubbles.
- Redirect: the target is requested on the cycle after BRANCH_TAKEN (zero-wait). The wrong-path slot in IF/ID is overwritten by NOP the same edge.
- STALL never loses an instruction: it is either not yet accepted (re-requested) or parked in HOLD_INSTR.

## Structure
- Shared package `fetch_pkg`:
  - FSM state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, DRAIN=2'd3)
  - NOP_INSTR constant
  - default RESET_PC
- One sub-module, `pc_reg`: PC register with synchronous active-low reset, load-enable, next-PC mux (PC+4 / BRANCH_TARGET / hold) and the +4 adder. The FSM, hold buffer and drain-address register stay in the top module.

## Test plan
- Reset then zero-wait memory returning 0x00A00093 at 0x0, 0x00100113 at 0x4 -> IF_ID_ENABLE=0 during reset; on consecutive cycles INSTRUCTION/PC_PLUS_4 = 0x00A00093/0x4, then 0x00100113/0x8.
- BUSYWAIT high 3 cycles on address 0x8 -> three NOP cycles with ENABLE=1, then word with PC_PLUS_4=0xC; IMEM_ADDRESS stable at 0x8 throughout.
- STALL high 2 cycles coinciding with accept at 0x10 -> ENABLE=0 both cycles, IMEM_READ=0 in HOLD; on release the held word is presented with PC_PLUS_4=0x14; next fetch is at 0x14.
- BRANCH_TAKEN target 0x100 with STALL=1 in the same FETCH cycle -> ENABLE=1 with NOP; next IMEM_ADDRESS=0x100.
- BRANCH_TAKEN target 0x40 while BUSYWAIT=1 at 0x20 -> DRAIN holds address 0x20 until BUSYWAIT drops; that data is not presented; next fetch is at 0x40.
- PC at 0xFFFF_FFFC, accept -> PC_PLUS_4=0x0, next IMEM_ADDRESS=0x0. RESET low during DRAIN -> IMEM_READ=0 the next cycle, PC=RESET_PC.
